// File: rtl/alu_regfile_sequencer.sv
// alu_regfile_sequencer
//
// Purpose:
//   Drives an external register file and ALU through a fixed self-test
//   program. Each step loads two operands derived from the step index k
//   into registers 1 and 2, holds the ALU operand selects for SETTLE_CYCLES
//   cycles, then captures the ALU result. The result is folded into an XOR
//   signature, and overflow/branch flags are counted with saturation. The
//   optional WRITEBACK state stores the captured result into register 3.
//
// Configuration:
//   SEQ_WRITEBACK_EN  defined   -> WRITEBACK state included (5-cycle step
//                                  with SETTLE_CYCLES=1)
//                     undefined -> CAPTURE ends the step (4-cycle step)
//
// Parameters:
//   NUM_STEPS      program steps per run (1..256)
//   SETTLE_CYCLES  EXEC cycles held before capture (1..15)
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous, active-low reset
//   start        one-cycle run request (ignored while busy)
//   rd0_addr     register-file read port 0 address
//   rd1_addr     register-file read port 1 address
//   wr_addr      register-file write address
//   wr_data      register-file write data (bit 8 always 0)
//   wr_en        register-file write strobe
//   instr_i      tied to 8'h00
//   alu_src1/2   tied to 0 (register operands)
//   alu_op       ALU operation select
//   result       ALU result
//   ovf          ALU overflow flag
//   take_branch  ALU branch flag
//   busy         high while a run is in progress
//   done         high while in DONE
//   signature    XOR of all captured results
//   led          mirror of signature
//   ovf_count    saturating count of captures with ovf=1
//   br_count     saturating count of captures with take_branch=1

module alu_regfile_sequencer #(
  parameter int NUM_STEPS     = 8,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [1:0] rd0_addr,
  output logic [1:0] rd1_addr,
  output logic [1:0] wr_addr,
  output logic [8:0] wr_data,
  output logic       wr_en,
  output logic [7:0] instr_i,
  output logic       alu_src1,
  output logic       alu_src2,
  output logic [2:0] alu_op,
  input  logic [7:0] result,
  input  logic       ovf,
  input  logic       take_branch,
  output logic       busy,
  output logic       done,
  output logic [7:0] signature,
  output logic [7:0] led,
  output logic [7:0] ovf_count,
  output logic [7:0] br_count
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] LOAD_A    = 3'd1;
  localparam logic [2:0] LOAD_B    = 3'd2;
  localparam logic [2:0] EXEC      = 3'd3;
  localparam logic [2:0] CAPTURE   = 3'd4;
  localparam logic [2:0] DONE      = 3'd5;
`ifdef SEQ_WRITEBACK_EN
  localparam logic [2:0] WRITEBACK = 3'd6;
`endif

  localparam logic [7:0] LAST_K      = 8'(NUM_STEPS - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  logic [2:0] state;
  logic [7:0] k;
  logic [3:0] settle_cnt;
  logic [7:0] k_times_17;
  logic       last_step;
`ifdef SEQ_WRITEBACK_EN
  logic [7:0] captured;
`endif

  // Product truncated to 8 bits gives (k*17) mod 256 directly.
  assign k_times_17 = k * 8'd17;
  assign last_step  = (k == LAST_K);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      k          <= 8'd0;
      settle_cnt <= 4'd0;
      signature  <= 8'd0;
      ovf_count  <= 8'd0;
      br_count   <= 8'd0;
`ifdef SEQ_WRITEBACK_EN
      captured   <= 8'd0;
`endif
    end else begin
      case (state)
        // Results stay frozen in DONE until a new start clears them.
        IDLE, DONE: begin
          if (start) begin
            state     <= LOAD_A;
            k         <= 8'd0;
            signature <= 8'd0;
            ovf_count <= 8'd0;
            br_count  <= 8'd0;
          end
        end
        LOAD_A: state <= LOAD_B;
        LOAD_B: begin
          state      <= EXEC;
          settle_cnt <= 4'd0;
        end
        EXEC: begin
          if (settle_cnt == SETTLE_LAST) begin
            state <= CAPTURE;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        CAPTURE: begin
          signature <= signature ^ result;
          if (ovf && (ovf_count != 8'hFF)) begin
            ovf_count <= ovf_count + 8'd1;
          end
          if (take_branch && (br_count != 8'hFF)) begin
            br_count <= br_count + 8'd1;
          end
`ifdef SEQ_WRITEBACK_EN
          captured <= result;
          state    <= WRITEBACK;
`else
          if (last_step) begin
            state <= DONE;
          end else begin
            k     <= k + 8'd1;
            state <= LOAD_A;
          end
`endif
        end
`ifdef SEQ_WRITEBACK_EN
        WRITEBACK: begin
          if (last_step) begin
            state <= DONE;
          end else begin
            k     <= k + 8'd1;
            state <= LOAD_A;
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  // Register-file and ALU drive is a pure function of state and k, so every
  // state not listed here (IDLE, DONE) drives all zeros.
  always_comb begin
    wr_en    = 1'b0;
    wr_addr  = 2'd0;
    wr_data  = 9'd0;
    rd0_addr = 2'd0;
    rd1_addr = 2'd0;
    alu_op   = 3'd0;
    case (state)
      LOAD_A: begin
        wr_en   = 1'b1;
        wr_addr = 2'd1;
        wr_data = {1'b0, k_times_17};
      end
      LOAD_B: begin
        wr_en   = 1'b1;
        wr_addr = 2'd2;
        wr_data = {1'b0, 8'hFF - k};
      end
      EXEC, CAPTURE: begin
        rd0_addr = 2'd1;
        rd1_addr = 2'd2;
        alu_op   = k[2:0];
      end
`ifdef SEQ_WRITEBACK_EN
      WRITEBACK: begin
        wr_en   = 1'b1;
        wr_addr = 2'd3;
        wr_data = {1'b0, captured};
      end
`endif
      default: ;
    endcase
  end

  assign busy     = (state != IDLE) && (state != DONE);
  assign done     = (state == DONE);
  assign led      = signature;
  assign instr_i  = 8'h00;
  assign alu_src1 = 1'b0;
  assign alu_src2 = 1'b0;

endmodule

// File: tb/tb_alu_regfile_sequencer.sv
module tb_alu_regfile_sequencer;

`ifdef SEQ_WRITEBACK_EN
  localparam int WB = 1;
`else
  localparam int WB = 0;
`endif
  // Step length: LOAD_A + LOAD_B + EXEC x settle + CAPTURE (+ WRITEBACK)
  localparam int SL0 = 4 + WB;
  localparam int SL2 = 5 + WB;

  logic       clk;
  logic       reset;
  logic       start [3];
  logic [1:0] rd0_addr [3];
  logic [1:0] rd1_addr [3];
  logic [1:0] wr_addr [3];
  logic [8:0] wr_data [3];
  logic       wr_en [3];
  logic [7:0] instr_i [3];
  logic       alu_src1 [3];
  logic       alu_src2 [3];
  logic [2:0] alu_op [3];
  logic [7:0] result [3];
  logic       ovf [3];
  logic       take_branch [3];
  logic       busy [3];
  logic       done [3];
  logic [7:0] signature [3];
  logic [7:0] led [3];
  logic [7:0] ovf_count [3];
  logic [7:0] br_count [3];

  int total;
  int bad;

  alu_regfile_sequencer u_dut0 (
    .clk(clk), .reset(reset), .start(start[0]),
    .rd0_addr(rd0_addr[0]), .rd1_addr(rd1_addr[0]), .wr_addr(wr_addr[0]),
    .wr_data(wr_data[0]), .wr_en(wr_en[0]), .instr_i(instr_i[0]),
    .alu_src1(alu_src1[0]), .alu_src2(alu_src2[0]), .alu_op(alu_op[0]),
    .result(result[0]), .ovf(ovf[0]), .take_branch(take_branch[0]),
    .busy(busy[0]), .done(done[0]), .signature(signature[0]), .led(led[0]),
    .ovf_count(ovf_count[0]), .br_count(br_count[0])
  );

  alu_regfile_sequencer #(.NUM_STEPS(3)) u_dut1 (
    .clk(clk), .reset(reset), .start(start[1]),
    .rd0_addr(rd0_addr[1]), .rd1_addr(rd1_addr[1]), .wr_addr(wr_addr[1]),
    .wr_data(wr_data[1]), .wr_en(wr_en[1]), .instr_i(instr_i[1]),
    .alu_src1(alu_src1[1]), .alu_src2(alu_src2[1]), .alu_op(alu_op[1]),
    .result(result[1]), .ovf(ovf[1]), .take_branch(take_branch[1]),
    .busy(busy[1]), .done(done[1]), .signature(signature[1]), .led(led[1]),
    .ovf_count(ovf_count[1]), .br_count(br_count[1])
  );

  alu_regfile_sequencer #(.NUM_STEPS(256), .SETTLE_CYCLES(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start[2]),
    .rd0_addr(rd0_addr[2]), .rd1_addr(rd1_addr[2]), .wr_addr(wr_addr[2]),
    .wr_data(wr_data[2]), .wr_en(wr_en[2]), .instr_i(instr_i[2]),
    .alu_src1(alu_src1[2]), .alu_src2(alu_src2[2]), .alu_op(alu_op[2]),
    .result(result[2]), .ovf(ovf[2]), .take_branch(take_branch[2]),
    .busy(busy[2]), .done(done[2]), .signature(signature[2]), .led(led[2]),
    .ovf_count(ovf_count[2]), .br_count(br_count[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    bit         pulse;
    logic       we;
    logic [1:0] wa;
    logic [8:0] wd;
    logic [1:0] r0;
    logic [1:0] r1;
    logic [2:0] op;
    logic       bsy;
    logic       dn;
  } vec_t;

  vec_t vecs[$];

  function automatic void addVec(int cyc, bit pulse, logic we, logic [1:0] wa,
                                 logic [8:0] wd, logic [1:0] r0, logic [1:0] r1,
                                 logic [2:0] op, logic bsy, logic dn);
    vec_t v;
    v.cyc = cyc; v.pulse = pulse; v.we = we; v.wa = wa; v.wd = wd;
    v.r0 = r0; v.r1 = r1; v.op = op; v.bsy = bsy; v.dn = dn;
    vecs.push_back(v);
  endfunction

  // One full step of the default instance (settle = 1, stub result 8'h5A).
  function automatic void addStep(int k, bit pulse, logic [8:0] da,
                                  logic [8:0] db, logic [2:0] op);
    int b;
    b = k * SL0;
    addVec(b,     pulse, 1'b1, 2'd1, da,     2'd0, 2'd0, 3'd0, 1'b1, 1'b0);
    addVec(b + 1, 1'b0,  1'b1, 2'd2, db,     2'd0, 2'd0, 3'd0, 1'b1, 1'b0);
    addVec(b + 2, 1'b0,  1'b0, 2'd0, 9'h000, 2'd1, 2'd2, op,   1'b1, 1'b0);
    addVec(b + 3, 1'b0,  1'b0, 2'd0, 9'h000, 2'd1, 2'd2, op,   1'b1, 1'b0);
    if (WB == 1)
      addVec(b + 4, 1'b0, 1'b1, 2'd3, 9'h05A, 2'd0, 2'd0, 3'd0, 1'b1, 1'b0);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Pulses start on one instance; returns #1 after the edge that samples it.
  task automatic applyStimulus(input int which);
    @(negedge clk);
    start[which] = 1'b1;
    @(posedge clk);
    #1;
    start[which] = 1'b0;
  endtask

  task automatic waitDone(input int which, input int budget, output int cycles);
    cycles = 0;
    while (!done[which] && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int  cur;
    int  cyc;
    bit  seen3;
    vec_t v;

    total = 0;
    bad   = 0;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) start[i] = 1'b0;
    result[0] = 8'h5A; ovf[0] = 1'b0; take_branch[0] = 1'b0;
    result[1] = 8'h5A; ovf[1] = 1'b1; take_branch[1] = 1'b1;
    result[2] = 8'h01; ovf[2] = 1'b1; take_branch[2] = 1'b1;

    // Reset held low for three edges, then released.
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("rst_busy", busy[0], 1'b0);
    checkOutput("rst_done", done[0], 1'b0);
    checkOutput("rst_wr_en", wr_en[0], 1'b0);
    checkOutput("rst_led", led[0], 8'h00);
    checkOutput("rst_sig", signature[0], 8'h00);
    checkOutput("rst_ovf", ovf_count[0], 8'h00);
    checkOutput("rst_br", br_count[0], 8'h00);
    checkOutput("rst_addrs", {rd0_addr[0], rd1_addr[0], wr_addr[0]}, 6'd0);
    checkOutput("rst_instr", instr_i[0], 8'h00);
    checkOutput("rst_src", {alu_src1[0], alu_src2[0]}, 2'b00);

    // Expected trace of a default run; k=2 also carries a mid-run start.
    addStep(0, 1'b0, 9'h000, 9'h0FF, 3'd0);
    addStep(2, 1'b1, 9'h022, 9'h0FD, 3'd2);
    addStep(7, 1'b0, 9'h077, 9'h0F8, 3'd7);
    addVec(8 * SL0, 1'b0, 1'b0, 2'd0, 9'h000, 2'd0, 2'd0, 3'd0, 1'b0, 1'b1);

    seen3 = 1'b0;
    applyStimulus(0);
    cur = 0;
    foreach (vecs[i]) begin
      v = vecs[i];
      while (cur < v.cyc) begin
        @(posedge clk);
        #1;
        start[0] = 1'b0;
        cur++;
        if (wr_en[0] && wr_addr[0] == 2'd3) seen3 = 1'b1;
      end
      checkOutput($sformatf("c%0d_wr_en", v.cyc), wr_en[0], v.we);
      checkOutput($sformatf("c%0d_wr_addr", v.cyc), wr_addr[0], v.wa);
      if (v.we)
        checkOutput($sformatf("c%0d_wr_data", v.cyc), wr_data[0], v.wd);
      checkOutput($sformatf("c%0d_rd0", v.cyc), rd0_addr[0], v.r0);
      checkOutput($sformatf("c%0d_rd1", v.cyc), rd1_addr[0], v.r1);
      checkOutput($sformatf("c%0d_alu_op", v.cyc), alu_op[0], v.op);
      checkOutput($sformatf("c%0d_busy", v.cyc), busy[0], v.bsy);
      checkOutput($sformatf("c%0d_done", v.cyc), done[0], v.dn);
      if (v.pulse) start[0] = 1'b1;
    end
    start[0] = 1'b0;
    checkOutput("run0_wb_seen", seen3, WB);
    checkOutput("run0_sig", signature[0], 8'h00);
    checkOutput("run0_led", led[0], 8'h00);
    checkOutput("run0_ovf", ovf_count[0], 8'h00);
    checkOutput("run0_br", br_count[0], 8'h00);

    // Three-step instance with both flags set every capture.
    applyStimulus(1);
    waitDone(1, 200, cyc);
    checkOutput("run1_len", cyc, 3 * SL0);
    checkOutput("run1_sig", signature[1], 8'h5A);
    checkOutput("run1_led", led[1], 8'h5A);
    checkOutput("run1_ovf", ovf_count[1], 8'd3);
    checkOutput("run1_br", br_count[1], 8'd3);
    result[1] = 8'hC3;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("hold1_done", done[1], 1'b1);
    checkOutput("hold1_sig", signature[1], 8'h5A);
    checkOutput("hold1_ovf", ovf_count[1], 8'd3);

    // Reset (with a simultaneous start) during EXEC of step 4.
    applyStimulus(2);
    repeat (4 * SL2 + 2) @(posedge clk);
    #1;
    checkOutput("mid_alu_op", alu_op[2], 3'd4);
    checkOutput("mid_ovf", ovf_count[2], 8'd4);
    checkOutput("mid_br", br_count[2], 8'd4);
    checkOutput("mid_busy", busy[2], 1'b1);
    reset    = 1'b0;
    start[2] = 1'b1;
    @(posedge clk);
    #1;
    reset    = 1'b1;
    start[2] = 1'b0;
    checkOutput("mrst_busy", busy[2], 1'b0);
    checkOutput("mrst_done", done[2], 1'b0);
    checkOutput("mrst_wr_en", wr_en[2], 1'b0);
    checkOutput("mrst_led", led[2], 8'h00);
    checkOutput("mrst_ovf", ovf_count[2], 8'h00);
    checkOutput("mrst_br", br_count[2], 8'h00);
    checkOutput("mrst_alu_op", alu_op[2], 3'd0);
    checkOutput("mrst_rd0", rd0_addr[2], 2'd0);
    checkOutput("mrst_done1", done[1], 1'b0);
    @(posedge clk);
    #1;
    checkOutput("mrst_start_dropped", busy[2], 1'b0);

    // Full 256-step rerun from k=0: counters saturate at 255.
    applyStimulus(2);
    checkOutput("rerun_wa", wr_addr[2], 2'd1);
    checkOutput("rerun_da", wr_data[2], 9'h000);
    @(posedge clk);
    #1;
    checkOutput("rerun_db", wr_data[2], 9'h0FF);
    waitDone(2, 3000, cyc);
    checkOutput("run2_len", cyc + 1, 256 * SL2);
    checkOutput("run2_ovf_sat", ovf_count[2], 8'hFF);
    checkOutput("run2_br_sat", br_count[2], 8'hFF);
    checkOutput("run2_sig", signature[2], 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
